// File: rtl/mtpsa_pkg.sv
// Shared definitions for the MTPSA user-output merge path.
//  - Default sizing of the per-user pipelines and the tuser layout
//    ({digest, metadata}).
//  - Arbiter FSM state encoding.
package mtpsa_pkg;

  localparam int NUM_USERS    = 8;
  localparam int DATA_WIDTH   = 256;
  localparam int META_WIDTH   = 40;
  localparam int DIGEST_WIDTH = 256;
  localparam int TUSER_WIDTH  = DIGEST_WIDTH + META_WIDTH;
  localparam int CNT_WIDTH    = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mtpsa_user_out_arbiter_if.sv
// AXIS bundle around the user-output arbiter.
//  s_axis_* : NUM_USERS packed input streams, user i at slice i.
//  m_axis_* : single merged output stream.
// Modports:
//  slave  : the arbiter's view (consumes s_axis, produces m_axis).
//  master : the environment's view (produces s_axis, consumes m_axis).
interface mtpsa_user_out_arbiter_if #(
  parameter int NUM_USERS   = mtpsa_pkg::NUM_USERS,
  parameter int DATA_WIDTH  = mtpsa_pkg::DATA_WIDTH,
  parameter int TUSER_WIDTH = mtpsa_pkg::TUSER_WIDTH
);
  import mtpsa_pkg::*;

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [NUM_USERS*DATA_WIDTH-1:0]  s_axis_tdata;
  logic [NUM_USERS*KEEP_WIDTH-1:0]  s_axis_tkeep;
  logic [NUM_USERS*TUSER_WIDTH-1:0] s_axis_tuser;
  logic [NUM_USERS-1:0]             s_axis_tvalid;
  logic [NUM_USERS-1:0]             s_axis_tlast;
  logic [NUM_USERS-1:0]             s_axis_tready;

  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic [KEEP_WIDTH-1:0]            m_axis_tkeep;
  logic [TUSER_WIDTH-1:0]           m_axis_tuser;
  logic                             m_axis_tvalid;
  logic                             m_axis_tlast;
  logic                             m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/mtpsa_axis_skid.sv
// 2-entry AXIS register slice (skid buffer).
//  axis_aclk/axis_resetn : clock, async active-low reset (valids only)
//  in_data/in_valid/in_ready    : upstream side, in_ready = skid entry free
//  out_data/out_valid/out_ready : downstream side, fully registered
// One cycle latency, full throughput; the payload is opaque.
module mtpsa_axis_skid #(
  parameter int W = 8
) (
  input  logic         axis_aclk,
  input  logic         axis_resetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  import mtpsa_pkg::*;

  logic [W-1:0] main_q, skid_q;
  logic         main_vld_q, skid_vld_q;

  // Registered ready: upstream sees a free slot only when the skid entry
  // is empty, so a beat arriving during a downstream stall has a home.
  assign in_ready  = !skid_vld_q;
  assign out_data  = main_q;
  assign out_valid = main_vld_q;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (skid_vld_q) begin
      // Skid drains into main; main stays valid.
      if (out_ready) skid_vld_q <= 1'b0;
    end else if (in_valid) begin
      if (!main_vld_q || out_ready) main_vld_q <= 1'b1;
      else                          skid_vld_q <= 1'b1;
    end else if (out_ready) begin
      main_vld_q <= 1'b0;
    end
  end

  // Payload needs no reset; mirrors the valid-path decisions above.
  always_ff @(posedge axis_aclk) begin
    if (skid_vld_q) begin
      if (out_ready) main_q <= skid_q;
    end else if (in_valid) begin
      if (!main_vld_q || out_ready) main_q <= in_data;
      else                          skid_q <= in_data;
    end
  end

endmodule

// File: rtl/mtpsa_user_out_arbiter.sv
// Merges NUM_USERS per-user AXIS pipelines into one stream.
//  axis_aclk/axis_resetn : clock, async active-low reset
//  axis (slave modport)  : per-user input streams and merged output
//  user_en   : per-user permission to win new arbitration
//  cnt_clr   : one-cycle pulse clearing all packet counters
//  pkt_cnt   : forwarded-packet count per user (user i at slice i)
//  cur_grant : owning user index, meaningful while busy
//  busy      : a packet currently owns the output
// Packet-level round robin: ownership only changes on an accepted tlast,
// so beats of different packets never interleave.
module mtpsa_user_out_arbiter #(
  parameter  int NUM_USERS   = mtpsa_pkg::NUM_USERS,
  parameter  int DATA_WIDTH  = mtpsa_pkg::DATA_WIDTH,
  parameter  int TUSER_WIDTH = mtpsa_pkg::TUSER_WIDTH,
  parameter  int CNT_WIDTH   = mtpsa_pkg::CNT_WIDTH,
  localparam int GW          = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
  input  logic                           axis_aclk,
  input  logic                           axis_resetn,
  mtpsa_user_out_arbiter_if.slave        axis,
  input  logic [NUM_USERS-1:0]           user_en,
  input  logic                           cnt_clr,
  output logic [NUM_USERS*CNT_WIDTH-1:0] pkt_cnt,
  output logic [GW-1:0]                  cur_grant,
  output logic                           busy
);
  import mtpsa_pkg::*;

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int PW         = DATA_WIDTH + KEEP_WIDTH + TUSER_WIDTH + 1;

  arb_state_e                          state_q, state_d;
  logic [GW-1:0]                       grant_d, rr_ptr_q, rr_ptr_d;
  logic [GW:0]                         pick;
  logic [NUM_USERS-1:0]                req, grant_oh, s_tready, cnt_inc;
  logic                                slice_in_valid, slice_in_ready;
  logic                                beat_acc, last_acc;
  logic [PW-1:0]                       slice_in, slice_out;
  logic [NUM_USERS-1:0][CNT_WIDTH-1:0] cnt_q;

  // Round-robin pick: rotate so ptr+1 sits at bit 0, take the lowest set
  // bit, map back to a user index. Returns {found, index}.
  function automatic logic [GW:0] rr_pick(input logic [NUM_USERS-1:0] r,
                                          input logic [GW-1:0]        ptr);
    logic [2*NUM_USERS-1:0] dbl;
    logic [NUM_USERS-1:0]   rot;
    int                     start, idx;
    rr_pick = '0;
    idx     = 0;
    start   = int'(ptr) + 1;
    dbl     = {r, r} >> start;
    rot     = dbl[NUM_USERS-1:0];
    for (int k = NUM_USERS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx     = (start + k) % NUM_USERS;
        rr_pick = {1'b1, idx[GW-1:0]};
      end
    end
  endfunction

  assign req  = axis.s_axis_tvalid & user_en;
  assign busy = (state_q == ARB_SEND);

  always_comb begin
    grant_oh            = '0;
    grant_oh[cur_grant] = 1'b1;
  end

  // Only the owner is steered into the slice; everyone else sees ready=0.
  assign slice_in_valid = busy && axis.s_axis_tvalid[cur_grant];
  assign beat_acc       = slice_in_valid && slice_in_ready;
  assign last_acc       = beat_acc && axis.s_axis_tlast[cur_grant];

  always_comb begin
    s_tready = '0;
    if (busy) s_tready[cur_grant] = slice_in_ready;
  end
  assign axis.s_axis_tready = s_tready;

  assign slice_in = {axis.s_axis_tdata[cur_grant*DATA_WIDTH +: DATA_WIDTH],
                     axis.s_axis_tkeep[cur_grant*KEEP_WIDTH +: KEEP_WIDTH],
                     axis.s_axis_tuser[cur_grant*TUSER_WIDTH +: TUSER_WIDTH],
                     axis.s_axis_tlast[cur_grant]};

  always_comb begin
    state_d  = state_q;
    grant_d  = cur_grant;
    rr_ptr_d = rr_ptr_q;
    pick     = '0;
    case (state_q)
      ARB_IDLE: begin
        pick = rr_pick(req, rr_ptr_q);
        if (pick[GW]) begin
          state_d = ARB_SEND;
          grant_d = pick[GW-1:0];
        end
      end
      ARB_SEND: begin
        if (last_acc) begin
          // Re-arbitrate in the tlast cycle for a zero-bubble handover;
          // the finishing user is masked so it cannot immediately re-win.
          rr_ptr_d = cur_grant;
          pick     = rr_pick(req & ~grant_oh, cur_grant);
          if (pick[GW]) grant_d = pick[GW-1:0];
          else          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= ARB_IDLE;
      cur_grant <= '0;
      rr_ptr_q  <= GW'(NUM_USERS - 1);
    end else begin
      state_q   <= state_d;
      cur_grant <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Counters: a clear coinciding with an increment lands on 1.
  assign cnt_inc = last_acc ? grant_oh : '0;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_USERS; i++) begin
        if (cnt_clr)         cnt_q[i] <= cnt_inc[i] ? CNT_WIDTH'(1) : '0;
        else if (cnt_inc[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign pkt_cnt = cnt_q;

  mtpsa_axis_skid #(.W(PW)) u_skid (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .in_data     (slice_in),
    .in_valid    (slice_in_valid),
    .in_ready    (slice_in_ready),
    .out_data    (slice_out),
    .out_valid   (axis.m_axis_tvalid),
    .out_ready   (axis.m_axis_tready)
  );

  assign {axis.m_axis_tdata, axis.m_axis_tkeep,
          axis.m_axis_tuser, axis.m_axis_tlast} = slice_out;

endmodule

// File: tb/tb_mtpsa_user_out_arbiter.sv
// Scoreboard bench for mtpsa_user_out_arbiter. Per-user beat queues feed
// the inputs; the expected output order is pushed when packets are loaded.
// Counters are 4 bits wide here so wrap-around is reachable.
module tb_mtpsa_user_out_arbiter;
  localparam int NU = 8;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int TW = 296;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [TW-1:0] user;
    logic          last;
  } beat_t;
  localparam int BW = $bits(beat_t);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NU-1:0]  user_en;
  logic           cnt_clr;
  logic [NU*CW-1:0] pkt_cnt;
  logic [2:0]     cur_grant;
  logic           busy;

  always #5 clk = ~clk;

  mtpsa_user_out_arbiter_if #(.NUM_USERS(NU), .DATA_WIDTH(DW), .TUSER_WIDTH(TW)) axis ();

  mtpsa_user_out_arbiter #(
    .NUM_USERS(NU), .DATA_WIDTH(DW), .TUSER_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .axis_aclk   (clk),
    .axis_resetn (rst_n),
    .axis        (axis),
    .user_en     (user_en),
    .cnt_clr     (cnt_clr),
    .pkt_cnt     (pkt_cnt),
    .cur_grant   (cur_grant),
    .busy        (busy)
  );

  beat_t         uq[NU][$];
  int            ug[NU][$];
  beat_t         exp_q[$];
  int            exp_cnt[NU];
  logic [NU-1:0] acc;
  bit            clr_arm, tog, stall_prev;
  beat_t         held;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NU*CW-1:0] cnt_model();
    logic [NU*CW-1:0] v;
    for (int u = 0; u < NU; u++) v[u*CW +: CW] = CW'(exp_cnt[u]);
    return v;
  endfunction

  task automatic present();
    for (int u = 0; u < NU; u++) begin
      logic  v;
      beat_t b;
      v = 1'b0;
      b = '0;
      if (uq[u].size() > 0) begin
        if (ug[u][0] == 0) begin
          v = 1'b1;
          b = uq[u][0];
        end
      end
      axis.s_axis_tvalid[u]          = v;
      axis.s_axis_tdata[u*DW +: DW]  = b.data;
      axis.s_axis_tkeep[u*KW +: KW]  = b.keep;
      axis.s_axis_tuser[u*TW +: TW]  = b.user;
      axis.s_axis_tlast[u]           = b.last;
    end
  endtask

  // Queue a packet for user u; gap_len idle cycles precede beat gap_at.
  task automatic load(input int u, input int nb, input int gap_at, input int gap_len,
                      input bit expect_out);
    beat_t      b;
    logic [319:0] t;
    for (int i = 0; i < nb; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
      b.data[15:0] = {i[7:0], u[7:0]};
      for (int w = 0; w < 10; w++) t[w*32 +: 32] = $urandom();
      b.user = t[TW-1:0];
      b.last = (i == nb - 1);
      b.keep = '1;
      if (b.last) begin
        b.keep    = $urandom();
        b.keep[0] = 1'b1;
      end
      uq[u].push_back(b);
      ug[u].push_back((i == gap_at) ? gap_len : 0);
      if (expect_out) exp_q.push_back(b);
    end
    if (expect_out) exp_cnt[u] = (exp_cnt[u] + 1) % (1 << CW);
    present();
  endtask

  // One clock: monitor/decide at negedge, advance stimulus after posedge.
  task automatic tick();
    beat_t ob;
    @(negedge clk);
    ob = {axis.m_axis_tdata, axis.m_axis_tkeep, axis.m_axis_tuser, axis.m_axis_tlast};
    if (stall_prev) begin
      chk("valid_held", BW'(axis.m_axis_tvalid), BW'(1));
      chk("data_held", ob, held);
    end
    stall_prev = 1'b0;
    if (axis.m_axis_tvalid) begin
      if (axis.m_axis_tready) begin
        chk("exp_pending", BW'(exp_q.size() != 0), BW'(1));
        if (exp_q.size() != 0) chk("out_beat", ob, exp_q.pop_front());
      end else begin
        stall_prev = 1'b1;
        held       = ob;
      end
    end
    chk("tready_onehot", BW'($countones(axis.s_axis_tready) <= 1), BW'(1));
    acc     = axis.s_axis_tvalid & axis.s_axis_tready;
    cnt_clr = clr_arm && acc[4] && axis.s_axis_tlast[4];
    if (cnt_clr) clr_arm = 1'b0;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int u = 0; u < NU; u++) begin
      if (acc[u]) begin
        void'(uq[u].pop_front());
        void'(ug[u].pop_front());
      end else if (!axis.s_axis_tvalid[u] && ug[u].size() > 0) begin
        if (ug[u][0] > 0) ug[u][0] = ug[u][0] - 1;
      end
    end
    if (tog) axis.m_axis_tready = ~axis.m_axis_tready;
    present();
  endtask

  function automatic bit pending(input logic [NU-1:0] mask);
    bit p;
    p = (exp_q.size() != 0);
    for (int u = 0; u < NU; u++) if (mask[u] && uq[u].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string tag, input logic [NU-1:0] mask);
    for (int n = 0; n < 2000; n++) begin
      if (!pending(mask)) break;
      tick();
    end
    chk({tag, "_drained"}, BW'(pending(mask)), BW'(0));
    repeat (2) tick();
  endtask

  task automatic flush();
    for (int u = 0; u < NU; u++) begin
      uq[u].delete();
      ug[u].delete();
      exp_cnt[u] = 0;
    end
    exp_q.delete();
    present();
  endtask

  initial begin
    rst_n   = 1'b0;
    user_en = '1;
    cnt_clr = 1'b0;
    clr_arm = 1'b0;
    tog     = 1'b0;
    stall_prev = 1'b0;
    axis.m_axis_tready = 1'b1;
    flush();
    repeat (3) tick();
    chk("rst_tready", BW'(axis.s_axis_tready), BW'(0));
    chk("rst_mvalid", BW'(axis.m_axis_tvalid), BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    chk("rst_grant", BW'(cur_grant), BW'(0));
    chk("rst_cnt", BW'(pkt_cnt), BW'(0));
    rst_n = 1'b1;
    tick();

    // 1) three simultaneous requesters, served 0,3,5 back to back
    load(0, 4, -1, 0, 1);
    load(3, 4, -1, 0, 1);
    load(5, 4, -1, 0, 1);
    tick();
    chk("t1_busy", BW'(busy), BW'(1));
    chk("t1_grant", BW'(cur_grant), BW'(0));
    chk("t1_tready", BW'(axis.s_axis_tready), BW'(8'h01));
    drain("t1", '1);
    chk("t1_cnt", BW'(pkt_cnt), BW'(cnt_model()));

    // 2) owner 6 stalls 5 cycles mid-packet; 2 must wait
    load(6, 4, 2, 5, 1);
    load(2, 3, -1, 0, 1);
    drain("t2", '1);
    chk("t2_cnt", BW'(pkt_cnt), BW'(cnt_model()));

    // 3) downstream backpressure 1010...
    tog = 1'b1;
    load(7, 8, -1, 0, 1);
    drain("t3", '1);
    tog = 1'b0;
    axis.m_axis_tready = 1'b1;
    tick();
    chk("t3_cnt", BW'(pkt_cnt), BW'(cnt_model()));

    // 4) enable withdrawn mid-packet; disabled user 1 never served
    user_en = 8'h01;
    load(0, 4, -1, 0, 1);
    load(1, 4, -1, 0, 0);
    repeat (3) tick();
    user_en = 8'h00;
    drain("t4", 8'h01);
    repeat (8) tick();
    chk("t4_busy", BW'(busy), BW'(0));
    chk("t4_cnt", BW'(pkt_cnt), BW'(cnt_model()));
    uq[1].delete();
    ug[1].delete();
    present();
    user_en = '1;
    tick();

    // 5) counter wrap and clear-with-increment
    for (int k = 0; k < 15; k++) load(4, 1, -1, 0, 1);
    drain("t5a", '1);
    chk("t5_full", BW'(pkt_cnt[4*CW +: CW]), BW'(4'hF));
    load(4, 1, -1, 0, 1);
    drain("t5b", '1);
    chk("t5_wrap", BW'(pkt_cnt), BW'(cnt_model()));
    chk("t5_wrap0", BW'(pkt_cnt[4*CW +: CW]), BW'(0));
    clr_arm = 1'b1;
    load(4, 1, -1, 0, 1);
    drain("t5c", '1);
    for (int u = 0; u < NU; u++) exp_cnt[u] = (u == 4) ? 1 : 0;
    chk("t5_clr", BW'(pkt_cnt), BW'(cnt_model()));

    // 6) reset in the middle of a packet, then fresh pointer
    axis.m_axis_tready = 1'b0;
    load(2, 4, -1, 0, 0);
    repeat (3) tick();
    chk("t6_pre_mvalid", BW'(axis.m_axis_tvalid), BW'(1));
    rst_n = 1'b0;
    stall_prev = 1'b0;
    flush();
    #1;
    chk("t6_mvalid", BW'(axis.m_axis_tvalid), BW'(0));
    chk("t6_tready", BW'(axis.s_axis_tready), BW'(0));
    chk("t6_busy", BW'(busy), BW'(0));
    chk("t6_cnt", BW'(pkt_cnt), BW'(0));
    axis.m_axis_tready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load(0, 2, -1, 0, 1);
    load(5, 2, -1, 0, 1);
    tick();
    chk("t6_grant", BW'(cur_grant), BW'(0));
    drain("t6", '1);
    chk("t6_cnt_end", BW'(pkt_cnt), BW'(cnt_model()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
